// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem reads and feeds IF/ID.
// One-entry hold buffer absorbs a fetched word while the pipe is stalled.
module fetch_stage #(
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    input  logic              halt,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    output logic              ifid_enable,
    output logic              ifid_flush,
    output logic [WORD_W-1:0] instruction_out,
    output logic [WORD_W-1:0] pcout_out,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] hold_instr;
    logic [WORD_W-1:0] hold_pc4;
    logic [31:0]       count;

    logic [WORD_W-1:0] pc4;
    logic              redirect;
    logic [WORD_W-1:0] target;
    logic              en;
    logic              flush;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pcout;

    assign pc4      = pc + WORD_W'(4);
    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;

    // Priority: halt > branch > jump > stall > ihit
    always_comb begin
        en    = 1'b0;
        flush = 1'b0;
        instr = '0;
        pcout = '0;
        if (state != HALTED) begin
            if (halt || redirect) begin
                flush = 1'b1;
            end else if (state == HOLD) begin
                if (!stall) begin
                    en    = 1'b1;
                    instr = hold_instr;
                    pcout = hold_pc4;
                end
            end else if (ihit && !stall) begin
                en    = 1'b1;
                instr = iload;
                pcout = pc4;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            hold_instr <= '0;
            hold_pc4   <= '0;
            count      <= '0;
        end else begin
            if (en && count != 32'hFFFF_FFFF)
                count <= count + 32'd1;
            case (state)
                FETCH, HOLD: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (redirect) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (state == HOLD) begin
                        if (!stall) begin
                            pc    <= hold_pc4;
                            state <= FETCH;
                        end
                    end else if (ihit) begin
                        if (stall) begin
                            hold_instr <= iload;
                            hold_pc4   <= pc4;
                            state      <= HOLD;
                        end else begin
                            pc <= pc4;
                        end
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

    // Outputs are forced low for the whole time reset is held
    assign iREN            = !RST && (state == FETCH);
    assign iaddr           = RST ? '0 : pc;
    assign ifid_enable     = !RST && en;
    assign ifid_flush      = !RST && flush;
    assign instruction_out = RST ? '0 : instr;
    assign pcout_out       = RST ? '0 : pcout;
    assign fetch_count     = RST ? '0 : count;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a queue-based
// model of the fetch pipeline front end.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0;
    logic [31:0] iload = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        halt = 1'b0;

    logic        a_ren, a_en, a_fl, b_ren, b_en, b_fl;
    logic [31:0] a_addr, a_ins, a_pco, a_cnt;
    logic [31:0] b_addr, b_ins, b_pco, b_cnt;

    always #5 CLK = ~CLK;

    fetch_stage dut_a (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt(halt),
        .iREN(a_ren), .iaddr(a_addr), .ifid_enable(a_en),
        .ifid_flush(a_fl), .instruction_out(a_ins), .pcout_out(a_pco),
        .fetch_count(a_cnt)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut_b (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt(halt),
        .iREN(b_ren), .iaddr(b_addr), .ifid_enable(b_en),
        .ifid_flush(b_fl), .instruction_out(b_ins), .pcout_out(b_pco),
        .fetch_count(b_cnt)
    );

    bit use_b = 1'b0;
    logic        o_ren, o_en, o_fl;
    logic [31:0] o_addr, o_ins, o_pco, o_cnt;
    assign o_ren  = use_b ? b_ren  : a_ren;
    assign o_en   = use_b ? b_en   : a_en;
    assign o_fl   = use_b ? b_fl   : a_fl;
    assign o_addr = use_b ? b_addr : a_addr;
    assign o_ins  = use_b ? b_ins  : a_ins;
    assign o_pco  = use_b ? b_pco  : a_pco;
    assign o_cnt  = use_b ? b_cnt  : a_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: PC, halted flag, a 0/1-deep queue of {instr, pc+4}
    logic [31:0] m_pc;
    bit          m_halted;
    logic [63:0] m_buf[$];
    logic [31:0] m_count;
    logic [31:0] last_ins, last_pco, last_en, last_fl;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = use_b ? 32'hFFFF_FFFC : 32'h0;
        m_halted = 1'b0;
        m_buf.delete();
        m_count  = '0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ren"},  32'(o_ren), 32'h0);
        chk({tag, "_addr"}, o_addr, 32'h0);
        chk({tag, "_en"},   32'(o_en), 32'h0);
        chk({tag, "_fl"},   32'(o_fl), 32'h0);
        chk({tag, "_ins"},  o_ins, 32'h0);
        chk({tag, "_pco"},  o_pco, 32'h0);
        chk({tag, "_cnt"},  o_cnt, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        ihit = 1'b0; stall = 1'b0; halt = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        #1;
        chk_zero("rst");
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic step(bit hi, logic [31:0] ld, bit st, bit b,
                        logic [31:0] bt, bit jj, logic [31:0] jt, bit hl);
        bit          e_ren, e_en, e_fl;
        logic [31:0] e_ins, e_pco;
        @(negedge CLK);
        ihit = hi; iload = ld; stall = st;
        branch_taken = b; branch_target = bt;
        jump = jj; jump_target = jt; halt = hl;
        #1;
        e_ren = !m_halted && m_buf.size() == 0;
        e_en = 1'b0; e_fl = 1'b0; e_ins = '0; e_pco = '0;
        if (m_halted) begin
            e_fl = 1'b0;
        end else if (hl || b || jj) begin
            e_fl = 1'b1;
        end else if (m_buf.size() != 0) begin
            if (!st) begin
                e_en = 1'b1;
                e_ins = m_buf[0][63:32];
                e_pco = m_buf[0][31:0];
            end
        end else if (hi && !st) begin
            e_en = 1'b1;
            e_ins = ld;
            e_pco = m_pc + 32'd4;
        end
        chk("iREN", 32'(o_ren), 32'(e_ren));
        chk("iaddr", o_addr, m_pc);
        chk("ifid_enable", 32'(o_en), 32'(e_en));
        chk("ifid_flush", 32'(o_fl), 32'(e_fl));
        chk("instruction_out", o_ins, e_ins);
        chk("pcout_out", o_pco, e_pco);
        chk("fetch_count", o_cnt, m_count);
        last_ins = o_ins; last_pco = o_pco;
        last_en = 32'(o_en); last_fl = 32'(o_fl);
        @(posedge CLK);
        if (e_en && m_count != 32'hFFFF_FFFF) m_count++;
        if (m_halted) begin
        end else if (hl) begin
            m_halted = 1'b1;
            m_buf.delete();
        end else if (b || jj) begin
            m_pc = b ? bt : jt;
            m_buf.delete();
        end else if (m_buf.size() != 0) begin
            if (!st) m_pc = m_buf.pop_front()[31:0];
        end else if (hi) begin
            if (st) m_buf.push_back({ld, m_pc + 32'd4});
            else m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic hit(bit st);
        step(1'b1, 32'hA000_0000 | m_pc, st, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset and streaming fetch
        do_reset();
        for (int i = 0; i < 4; i++) hit(1'b0);
        #1;
        chk("t1_count", o_cnt, 32'd4);
        chk("t1_iaddr", o_addr, 32'd16);

        // Stall with hold buffer at PC=8
        do_reset();
        hit(1'b0);
        hit(1'b0);
        step(1'b1, 32'h2001_0005, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 32'h1111_1111, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, 32'h2222_2222, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("t2_ins", last_ins, 32'h2001_0005);
        chk("t2_pco", last_pco, 32'd12);
        hit(1'b0);

        // Branch with same-cycle hit, then branch+jump+stall
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h40, 1'b0, '0, 1'b0);
        chk("t3_en", last_en, 32'd0);
        hit(1'b0);
        step(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h80, 1'b1, 32'hC0, 1'b0);
        chk("t4_fl", last_fl, 32'd1);
        hit(1'b0);

        // Halt while holding
        hit(1'b1);
        step(1'b1, '0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("t5_fl", last_fl, 32'd1);
        for (int i = 0; i < 6; i++)
            step(1'(i), $urandom, 1'(i >> 1), 1'b0, '0, 1'b0, '0, 1'b0);
        do_reset();
        hit(1'b0);

        // Wrapping PC and asynchronous reset mid-wait
        use_b = 1'b1;
        do_reset();
        hit(1'b0);
        chk("t6_pco", last_pco, 32'h0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge CLK);
        ihit = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk_zero("async");
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        hit(1'b0);
        use_b = 1'b0;

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            step($urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 7) == 0, $urandom,
                 $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the pipelined processor. Owns the program counter and issues instruction-memory reads. Presents fetched instruction and PC+4 to the IF/ID pipeline register, and drives that register's enable and flush. Handles stalls with a one-entry hold buffer, branch/jump redirects and halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, instruction/address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
ihit  in  1  imem read for current iaddr complete this cycle
iload  in  WORD_W  imem read data, valid when ihit=1
stall  in  1  downstream cannot accept (hazard unit / dcache wait)
branch_taken  in  1  older branch resolved taken
branch_target  in  WORD_W  branch redirect address
jump  in  1  jump/jr/jal redirect from decode
jump_target  in  WORD_W  jump redirect address
halt  in  1  halt reached writeback
iREN  out  1  imem read enable
iaddr  out  WORD_W  imem read address (= PC)
ifid_enable  out  1  IF/ID enable; one instruction delivered
ifid_flush  out  1  IF/ID flush
instruction_out  out  WORD_W  instruction to IF/ID
pcout_out  out  WORD_W  PC+4 of delivered instruction
fetch_count  out  32  delivered-instruction counter

Behaviour:
- States: FETCH (request outstanding), HOLD (instruction buffered, waiting for stall release), HALTED.
- Reset (async, RST=1): PC=PC_INIT, state=FETCH, hold buffer=0, fetch_count=0. All outputs 0 while RST=1. iaddr=PC_INIT after release.
- iREN = (state==FETCH). iaddr = PC in all states.
- Event priority per cycle: halt > branch_taken > jump > stall > ihit.
- FETCH, ihit=1, stall=0, no redirect:
  - ifid_enable=1 same cycle.
  - instruction_out=iload, pcout_out=PC+4.
  - PC<=PC+4, stay FETCH.
  - Zero added latency beyond imem.
- FETCH, ihit=1, stall=1:
  - Buffer iload and PC+4, go to HOLD.
  - ifid_enable=0. PC unchanged.
- FETCH, ihit=0: hold PC, iREN stays 1, ifid_enable=0.
- HOLD:
  - iREN=0.
  - When stall=0: ifid_enable=1, instruction_out/pcout_out from buffer, PC<=buffered PC+4, go FETCH.
  - When stall=1: remain in HOLD, outputs held.
- Redirect (branch_taken, or jump without branch_taken), in FETCH or HOLD:
  - PC<=target, ifid_flush=1 for that cycle, ifid_enable=0.
  - Any same-cycle ihit data or buffered data is discarded. Go FETCH.
  - Redirect overrides stall.
  - Targets used as-is, no alignment check.
- halt=1 from any state: go HALTED next edge, ifid_flush=1 that cycle. HALTED holds iREN=0, ifid_enable=0, ifid_flush=0 until RST.
- PC+4 wraps modulo 2^WORD_W (32'hFFFF_FFFC+4 = 0).
- fetch_count increments on every ifid_enable=1 cycle and saturates at 32'hFFFF_FFFF.
- instruction_out and pcout_out are 0 when ifid_enable=0.
- Reset mid-request: outstanding ihit is ignored. Fetch restarts at PC_INIT.

Test Plan:
1. Reset, then ihit=1 every cycle with iload=addr-tagged words → iaddr 0,4,8,12. ifid_enable=1 every cycle. pcout_out 4,8,12,16. fetch_count=4 after 4 cycles.
2. ihit=1 with stall=1 for 3 cycles, iload=32'h2001_0005 at PC=8 → HOLD, iREN=0, PC stays 8. On stall release: ifid_enable=1, instruction_out=32'h2001_0005, pcout_out=12, next iaddr=12.
3. branch_taken=1 with target 32'h40 in the same cycle as ihit → ifid_flush=1, ifid_enable=0, fetched word dropped, next iaddr=32'h40.
4. branch_taken (target 32'h80) and jump (target 32'hC0) same cycle, also stall=1 → iaddr=32'h80 next cycle, ifid_flush=1.
5. halt=1 while in HOLD → ifid_flush=1 once, then iREN=0 and ifid_enable=0 indefinitely despite ihit/stall toggling. RST pulse restores iaddr=PC_INIT.
6. PC_INIT=32'hFFFF_FFFC with ihit=1 → pcout_out=0 and next iaddr=0. RST asserted mid-wait (ihit=0) → all outputs 0 immediately, asynchronously.
